// File: rtl/dmem_ctrl_if.sv
// Request/response bus between the LSU (master) and dmem_ctrl (slave).
interface dmem_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Single-port data memory with self-initialisation, byte-enable writes and a probe port.
// Define DMEM_RDREG_EN to add a second response register (2-cycle latency).
module dmem_ctrl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    dmem_ctrl_if.slave               bus,
    output logic                     init_busy,
    input  logic [$clog2(DEPTH)-1:0] probe_addr,
    output logic [DATA_W-1:0]        probe_data
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {INIT, RUN} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   cnt, cnt_nxt;
    logic               init_we;

    logic [DATA_W-1:0]  ram [DEPTH];

    logic               accept;
    logic               misaligned;
    logic               out_of_range;
    logic               addr_err;
    logic               wr_en;
    logic [IDX_W-1:0]   idx;
    logic [DATA_W-1:0]  cur_word;
    logic [DATA_W-1:0]  wr_word;

    logic               s1_valid;
    logic               s1_err;
    logic [DATA_W-1:0]  s1_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        init_we       = 1'b0;
        init_busy     = 1'b0;
        bus.req_ready = 1'b0;
        case (state)
            INIT: begin
                init_busy = 1'b1;
                init_we   = 1'b1;
                cnt_nxt   = cnt + 1'b1;
                if (cnt == IDX_W'(DEPTH - 1))
                    state_nxt = RUN;
            end
            RUN: begin
                bus.req_ready = 1'b1;
            end
            default: state_nxt = INIT;
        endcase
    end

    assign accept       = bus.req_valid && bus.req_ready;
    assign idx          = bus.req_addr[OFF_W +: IDX_W];
    assign misaligned   = |bus.req_addr[OFF_W-1:0];
    assign out_of_range = |(bus.req_addr >> (OFF_W + IDX_W));
    assign addr_err     = misaligned || out_of_range;
    assign wr_en        = accept && bus.req_we && !addr_err;
    assign cur_word     = ram[idx];

    // Merge enabled bytes into the current word so the RAM sees one full-word write.
    always_comb begin
        wr_word = cur_word;
        for (int unsigned k = 0; k < BE_W; k++) begin
            if (bus.req_be[k])
                wr_word[8*k +: 8] = bus.req_wdata[8*k +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (init_we)
            ram[cnt] <= DATA_W'(cnt);
        else if (wr_en)
            ram[idx] <= wr_word;
    end

    assign probe_data = ram[probe_addr];

    // Read data is captured at the acceptance edge, so a preceding write is already visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_rdata <= '0;
        end else begin
            s1_valid <= accept;
            s1_err   <= accept && addr_err;
            s1_rdata <= (accept && !bus.req_we && !addr_err) ? cur_word : '0;
        end
    end

`ifdef DMEM_RDREG_EN
    logic               s2_valid;
    logic               s2_err;
    logic [DATA_W-1:0]  s2_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_err   <= 1'b0;
            s2_rdata <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_err   <= s1_err;
            s2_rdata <= s1_rdata;
        end
    end

    assign bus.rsp_valid = s2_valid;
    assign bus.rsp_err   = s2_err;
    assign bus.rsp_rdata = s2_rdata;
`else
    assign bus.rsp_valid = s1_valid;
    assign bus.rsp_err   = s1_err;
    assign bus.rsp_rdata = s1_rdata;
`endif
endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: directed plan items plus random traffic against a word-array model.
module tb_dmem_ctrl;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 32;
`ifdef DMEM_RDREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        init_busy;
    logic [5:0]  probe_addr;
    logic [31:0] probe_data;

    dmem_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    dmem_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .init_busy  (init_busy),
        .probe_addr (probe_addr),
        .probe_data (probe_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] model [DEPTH];

    task automatic model_init();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'(i);
    endtask

    // Monitor: pops one expectation per response pulse; flags late or missing ones.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (bus.rsp_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_rdata", bus.rsp_rdata, e.rd);
                    chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                    chk("rsp_latency", 32'(cyc - e.acc + 1), 32'(LAT));
                end
            end else begin
                chk("idle_rdata", bus.rsp_rdata, 32'd0);
                chk("idle_err", 32'(bus.rsp_err), 32'd0);
                if (sbq.size() != 0 && (cyc - sbq[0].acc + 1) >= LAT) begin
                    e = sbq.pop_front();
                    chk("missing_rsp", 32'd0, 32'd1);
                end
            end
        end
    end

    // Called at a negedge; drives one request and returns at the next negedge.
    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be);
        exp_t e;
        int   w;
        chk("req_ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_be    = be;
        e.rd  = 32'd0;
        e.err = (addr % 4 != 0) || (addr >= 32'(DEPTH * 4));
        e.acc = cyc + 1;
        if (!e.err) begin
            w = int'(addr / 4);
            if (we) begin
                for (int k = 0; k < 4; k++)
                    if (be[k]) model[w][8*k +: 8] = wd[8*k +: 8];
            end else begin
                e.rd = model[w];
            end
        end
        sbq.push_back(e);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic release_and_init();
        int n;
        rst = 1'b1;
        model_init();
        n = 0;
        while (init_busy === 1'b1 && n < 200) begin
            chk("init_ready_low", 32'(bus.req_ready), 32'd0);
            n++;
            @(negedge clk);
        end
        chk("init_cycles", 32'(n), 32'(DEPTH));
    endtask

    task automatic probe_sweep();
        for (int i = 0; i < DEPTH; i++) begin
            probe_addr = 6'(i);
            #1;
            chk($sformatf("probe[%0d]", i), probe_data, model[i]);
        end
        @(negedge clk);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
        probe_addr    = '0;

        repeat (3) @(negedge clk);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("reset_ready", 32'(bus.req_ready), 32'd0);
        chk("reset_busy", 32'(init_busy), 32'd1);

        release_and_init();
        probe_addr = 6'd5;
        #1 chk("probe_5", probe_data, 32'h0000_0005);
        probe_addr = 6'd63;
        #1 chk("probe_63", probe_data, 32'h0000_003F);
        @(negedge clk);

        issue(1'b1, 32'h10, 32'hAABB_CCDD, 4'b0101);
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        issue(1'b1, 32'h20, 32'h1234_5678, 4'hF);
        issue(1'b0, 32'h20, 32'h0, 4'h0);
        issue(1'b1, 32'h24, 32'hFFFF_FFFF, 4'h0);
        issue(1'b0, 32'h24, 32'h0, 4'h0);
        issue(1'b0, 32'h2, 32'h0, 4'h0);
        issue(1'b1, 32'h100, 32'hCAFE_F00D, 4'hF);
        issue(1'b0, 32'h100, 32'h0, 4'h0);
        issue(1'b1, 32'h1, 32'hCAFE_F00D, 4'hF);
        probe_sweep();

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            int sel;
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                continue;
            end
            sel = int'($urandom_range(0, 9));
            if (sel == 0)
                a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
            else if (sel == 1)
                a = $urandom | (32'h100 << $urandom_range(0, 23));
            else if (sel < 6)
                a = 32'($urandom_range(0, 7) * 4);
            else
                a = 32'($urandom_range(0, DEPTH - 1) * 4);
            issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
        end
        repeat (4) @(negedge clk);
        probe_sweep();

        issue(1'b1, 32'h20, 32'hDEAD_BEEF, 4'hF);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h20;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        sbq.delete();
        #1 chk("midrst_rsp_drop", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        chk("midrst_rsp_low", 32'(bus.rsp_valid), 32'd0);
        chk("midrst_busy", 32'(init_busy), 32'd1);
        @(negedge clk);
        release_and_init();
        issue(1'b0, 32'h20, 32'h0, 4'h0);
        probe_addr = 6'd8;
        #1 chk("probe_8_after_reinit", probe_data, 32'h0000_0008);
        @(negedge clk);

        for (int n = 0; n < 10 && sbq.size() != 0; n++) @(negedge clk);
        chk("drain_empty", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
